// File: rtl/tx_sched_if.sv
// Control/status bundle between the register bank and the tx burst sequencer.
// The master side drives the control inputs and reads status; the
// sequencer sits on the slave side.
interface tx_sched_if #(
    parameter int OS    = 4,
    parameter int CNT_W = 16
);
    localparam int PH_W = (OS > 1) ? $clog2(OS) : 1;

    logic             i_start;
    logic             i_stop;
    logic [CNT_W-1:0] i_burst_len;
    logic [PH_W-1:0]  i_phase_ofs;

    logic             o_sym_en;
    logic [PH_W-1:0]  o_phase;
    logic             o_fill;
    logic             o_out_valid;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_sym_cnt;

    modport master (
        output i_start, i_stop, i_burst_len, i_phase_ofs,
        input  o_sym_en, o_phase, o_fill, o_out_valid, o_busy, o_done, o_sym_cnt
    );

    modport slave (
        input  i_start, i_stop, i_burst_len, i_phase_ofs,
        output o_sym_en, o_phase, o_fill, o_out_valid, o_busy, o_done, o_sym_cnt
    );
endinterface

// File: rtl/tx_sched.sv
// Burst sequencer for the polyphase QPSK transmit filter.
// A burst primes the delay line with NSYM fill symbols, streams data symbols
// until the burst length is reached or a stop is requested, drains with NSYM
// fill symbols and pulses done. Every state boundary lands on the last phase
// of a symbol period so the filter always sees whole symbols.
module tx_sched #(
    parameter int OS    = 4,
    parameter int NSYM  = 6,
    parameter int CNT_W = 16
) (
    input logic       clk,
    input logic       rst,
    tx_sched_if.slave bus
);
    localparam int PH_W = (OS > 1) ? $clog2(OS) : 1;
    localparam int SC_W = $clog2(NSYM + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS - 1);
    localparam logic [SC_W-1:0] SEG_LEN = SC_W'(NSYM);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [PH_W-1:0]  phase;
    logic [SC_W-1:0]  seg_cnt;
    logic             stop_lat;
    logic [CNT_W-1:0] burst_len_q;
    logic [CNT_W-1:0] sym_cnt;
    logic             out_valid_q;

    logic active;
    logic sym_en;
    logic sym_end;
    logic start_ok;
    logic burst_full;

    assign active     = (state == PRIME) || (state == RUN) || (state == DRAIN);
    assign sym_en     = active && (phase == '0);
    assign sym_end    = active && (phase == PH_LAST);
    assign start_ok   = (state == IDLE) && bus.i_start && !bus.i_stop;
    assign burst_full = (burst_len_q != '0) && (sym_cnt == burst_len_q);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic; transitions only fire on the last phase of a symbol.
    // NOTE: state_nx gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = PRIME;
            PRIME:   if (sym_end && seg_cnt == SEG_LEN) state_nx = stop_lat ? DRAIN : RUN;
            RUN:     if (sym_end && (burst_full || stop_lat)) state_nx = DRAIN;
            DRAIN:   if (sym_end && seg_cnt == SEG_LEN) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Polyphase counter: loaded with the start offset, free-runs while active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (state == IDLE) begin
            phase <= start_ok ? bus.i_phase_ofs : '0;
        end else if (active) begin
            phase <= phase + PH_W'(1);
        end
    end

    // Per-state symbol counter; restarts on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_cnt <= '0;
        end else if (state_nx != state) begin
            seg_cnt <= '0;
        end else if (sym_en && seg_cnt != SEG_LEN) begin
            seg_cnt <= seg_cnt + SC_W'(1);
        end
    end

    // Stop request latch; only PRIME and RUN listen, cleared around IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_lat <= 1'b0;
        end else if (state == IDLE || state == DONE) begin
            stop_lat <= 1'b0;
        end else if ((state == PRIME || state == RUN) && bus.i_stop) begin
            stop_lat <= 1'b1;
        end
    end

    // Burst length capture and saturating data-symbol counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_len_q <= '0;
            sym_cnt     <= '0;
        end else if (start_ok) begin
            burst_len_q <= bus.i_burst_len;
            sym_cnt     <= '0;
        end else if (state == RUN && sym_en && sym_cnt != '1) begin
            sym_cnt <= sym_cnt + CNT_W'(1);
        end
    end

    // Output-valid lags RUN/DRAIN by one clock to match the filter's output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) out_valid_q <= 1'b0;
        else      out_valid_q <= (state == RUN) || (state == DRAIN);
    end

    assign bus.o_sym_en    = sym_en;
    assign bus.o_phase     = phase;
    assign bus.o_fill      = (state != RUN);
    assign bus.o_out_valid = out_valid_q;
    assign bus.o_busy      = (state != IDLE);
    assign bus.o_done      = (state == DONE);
    assign bus.o_sym_cnt   = sym_cnt;
endmodule

// File: tb/tb_tx_sched.sv
// Self-checking bench for tx_sched. The reference model derives each burst's
// timeline (prime end, data symbol count, drain end) arithmetically from the
// start offset, burst length and stop time, then predicts every output on
// every cycle from that timeline.
module tb_tx_sched;
    localparam int OS    = 4;
    localparam int NSYM  = 6;
    localparam int CNT_W = 16;
    localparam int PH_W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    tx_sched_if #(.OS(OS), .CNT_W(CNT_W)) bus ();

    tx_sched #(.OS(OS), .NSYM(NSYM), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int last_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input int busy, input int ph, input int sym_en,
                                 input int fill, input int ov, input int done, input int cnt);
        check({tag, ".busy"},      32'(bus.o_busy),      32'(busy));
        check({tag, ".phase"},     32'(bus.o_phase),     32'(ph));
        check({tag, ".sym_en"},    32'(bus.o_sym_en),    32'(sym_en));
        check({tag, ".fill"},      32'(bus.o_fill),      32'(fill));
        check({tag, ".out_valid"}, 32'(bus.o_out_valid), 32'(ov));
        check({tag, ".done"},      32'(bus.o_done),      32'(done));
        check({tag, ".sym_cnt"},   32'(bus.o_sym_cnt),   32'(cnt));
    endtask

    task automatic check_idle(input string tag);
        check_outputs(tag, 0, 0, 0, 1, 0, 0, last_cnt);
    endtask

    // One burst. stop_at/spam_at/abort_at are cycle numbers after the start
    // edge (cycle 1 is the first cycle after it); values < 1 disable them.
    task automatic run_burst(input string tag, input int len, input int ofs,
                             input int stop_at, input int spam_at, input int abort_at);
        int f, p_end, n_run, r_end, d_end, ns;
        int e_busy, e_ph, e_en, e_fill, e_ov, e_done, e_cnt;

        check_idle({tag, ".pre"});
        bus.i_burst_len = CNT_W'(len);
        bus.i_phase_ofs = PH_W'(ofs);
        bus.i_stop      = 1'b0;
        bus.i_start     = 1'b1;
        step();
        bus.i_start     = 1'b0;
        bus.i_burst_len = CNT_W'($urandom);
        bus.i_phase_ofs = PH_W'($urandom);

        // Timeline of the burst in cycles after the start edge.
        f     = ((OS - ofs) % OS) + 1;
        p_end = f + NSYM * OS - 1;
        if (stop_at >= 1 && stop_at < p_end) begin
            n_run = 0;
        end else begin
            n_run = len;
            if (stop_at >= 1) begin
                ns = (stop_at - p_end) / OS + 1;
                if (len == 0 || ns < len) n_run = ns;
            end
        end
        r_end = p_end + n_run * OS;
        d_end = r_end + NSYM * OS;

        for (int k = 1; k <= d_end + 2; k++) begin
            if (k == abort_at) begin
                rst = 1'b0;
                #2;
                last_cnt = 0;
                check_idle({tag, ".async_rst"});
                step();
                step();
                rst = 1'b1;
                bus.i_stop  = 1'b0;
                bus.i_start = 1'b0;
                return;
            end
            e_busy = int'(k <= d_end + 1);
            e_ph   = (k <= d_end + 1) ? (ofs + k - 1) % OS : 0;
            e_en   = int'(k <= d_end && e_ph == 0);
            e_fill = int'(!(k > p_end && k <= r_end));
            e_ov   = int'(k > p_end + 1 && k <= d_end + 1);
            e_done = int'(k == d_end + 1);
            e_cnt  = (k <= p_end + 1) ? 0 : (k - p_end - 1 + OS - 1) / OS;
            if (e_cnt > n_run) e_cnt = n_run;
            check_outputs(tag, e_busy, e_ph, e_en, e_fill, e_ov, e_done, e_cnt);

            bus.i_stop  = (k == stop_at);
            bus.i_start = (k == spam_at && k <= d_end + 1);
            if (bus.i_start) begin
                bus.i_burst_len = CNT_W'($urandom);
                bus.i_phase_ofs = PH_W'($urandom);
            end
            step();
        end
        bus.i_stop  = 1'b0;
        bus.i_start = 1'b0;
        last_cnt    = n_run;
    endtask

    initial begin
        int len, ofs, stop_at, spam_at;

        bus.i_start     = 1'b0;
        bus.i_stop      = 1'b0;
        bus.i_burst_len = '0;
        bus.i_phase_ofs = '0;

        // Reset held for three clocks, then quiet idle.
        repeat (3) begin
            step();
            check_idle("reset");
        end
        rst = 1'b1;
        repeat (20) begin
            step();
            check_idle("idle");
        end

        run_burst("b3_ofs0", 3, 0, -1, -1, -1);
        run_burst("b2_ofs2", 2, 2, -1, -1, -1);
        // Continuous burst; stop one cycle after the 10th data strobe (cycle 61).
        run_burst("cont_stop", 0, 0, 62, -1, -1);
        // Stop while priming: RUN skipped, done at cycle 49.
        run_burst("stop_prime", 5, 0, 10, -1, -1);

        // Start together with stop in IDLE is refused.
        bus.i_burst_len = CNT_W'(3);
        bus.i_start     = 1'b1;
        bus.i_stop      = 1'b1;
        step();
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        repeat (5) begin
            check_idle("start_and_stop");
            step();
        end

        // Asynchronous reset mid-RUN, then the same burst in full.
        run_burst("abort", 2, 2, -1, -1, 30);
        step();
        run_burst("after_abort", 2, 2, -1, -1, -1);

        // Start pulse during RUN is ignored.
        run_burst("start_in_run", 3, 1, -1, 30, -1);

        // Randomized bursts.
        for (int i = 0; i < 12; i++) begin
            len = $urandom_range(0, 5);
            ofs = $urandom_range(0, OS - 1);
            if (len == 0)                 stop_at = $urandom_range(1, 80);
            else if ($urandom_range(0, 1)) stop_at = $urandom_range(1, 60);
            else                          stop_at = -1;
            spam_at = $urandom_range(1, 60);
            run_burst($sformatf("rand%0d", i), len, ofs, stop_at, spam_at, -1);
            repeat ($urandom_range(0, 4)) begin
                check_idle($sformatf("rand%0d.gap", i));
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
